// File: rtl/vram_write_scheduler_if.sv
// vram_write_scheduler_if: bus bundle between the CPU/fill sources and the VRAM write scheduler.
//   master: drives CPU write, fill engine, vblank and overflow-clear inputs
//   slave:  the scheduler; drives VRAM write port, mode and FIFO status
interface vram_write_scheduler_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 16
);
    localparam int PW = $clog2(DEPTH);
    logic [ADDR_WIDTH-1:0] cpu_address;
    logic [7:0]            cpu_data;
    logic                  cpu_write_enable;
    logic [ADDR_WIDTH-1:0] fill_address;
    logic [7:0]            fill_data;
    logic                  fill_write_enable;
    logic                  fill_in_progress;
    logic                  in_vblank;
    logic                  clr_overflow;
    logic [ADDR_WIDTH-1:0] vram_address;
    logic [7:0]            vram_data;
    logic                  vram_write_enable;
    logic [1:0]            mode;
    logic [PW:0]           pending;
    logic                  full;
    logic                  overflow;
    modport master (
        output cpu_address, cpu_data, cpu_write_enable,
        output fill_address, fill_data, fill_write_enable, fill_in_progress,
        output in_vblank, clr_overflow,
        input  vram_address, vram_data, vram_write_enable, mode, pending, full, overflow
    );
    modport slave (
        input  cpu_address, cpu_data, cpu_write_enable,
        input  fill_address, fill_data, fill_write_enable, fill_in_progress,
        input  in_vblank, clr_overflow,
        output vram_address, vram_data, vram_write_enable, mode, pending, full, overflow
    );
endinterface

// File: rtl/vram_write_scheduler.sv
// vram_write_scheduler: sequences fill-engine and CPU writes onto the VRAM write port.
//   clk_12_5875: pixel clock; rst_n: async active-low reset
//   bus (slave): CPU/fill inputs, in_vblank, clr_overflow in;
//                registered vram_address/data/write_enable, mode, pending/full/overflow out
// Fill passes straight through; CPU writes queue in a FIFO and drain one per clock in vblank.
module vram_write_scheduler #(
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 16
) (
    input logic                  clk_12_5875,
    input logic                  rst_n,
    vram_write_scheduler_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [1:0] IDLE = 2'd0, FILL = 2'd1, DRAIN = 2'd2;
    logic [ADDR_WIDTH+7:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [PW:0]           pending;
    logic                  full, push, pop, overflow, vram_we;
    logic [ADDR_WIDTH-1:0] vram_address;
    logic [7:0]            vram_data;
    logic [1:0]            mode;
    // full is the pre-pop occupancy, so a write arriving while full is dropped even on a pop cycle
    assign full = pending == (PW+1)'(DEPTH);
    assign push = bus.cpu_write_enable && !full;
    assign pop  = !bus.fill_in_progress && bus.in_vblank && pending != '0;
    always_ff @(posedge clk_12_5875)
        if (push) mem[wr_ptr] <= {bus.cpu_address, bus.cpu_data};
    always_ff @(posedge clk_12_5875 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            pending      <= '0;
            overflow     <= 1'b0;
            mode         <= IDLE;
            vram_we      <= 1'b0;
            vram_address <= '0;
            vram_data    <= '0;
        end else begin
            wr_ptr   <= wr_ptr + PW'(push);
            rd_ptr   <= rd_ptr + PW'(pop);
            pending  <= pending + (PW+1)'(push) - (PW+1)'(pop);
            overflow <= (bus.cpu_write_enable && full) || (overflow && !bus.clr_overflow);
            mode     <= bus.fill_in_progress ? FILL : pop ? DRAIN : IDLE;
            if (bus.fill_in_progress) begin
                vram_address <= bus.fill_address;
                vram_data    <= bus.fill_data;
                vram_we      <= bus.fill_write_enable;
            end else if (pop) begin
                {vram_address, vram_data} <= mem[rd_ptr];
                vram_we                   <= 1'b1;
            end else begin
                vram_we <= 1'b0;
            end
        end
    end
    assign bus.vram_address      = vram_address;
    assign bus.vram_data         = vram_data;
    assign bus.vram_write_enable = vram_we;
    assign bus.mode              = mode;
    assign bus.pending           = pending;
    assign bus.full              = full;
    assign bus.overflow          = overflow;
endmodule

// File: tb/tb_vram_write_scheduler.sv
// tb_vram_write_scheduler: directed stimulus with a scoreboard of expected VRAM writes.
module tb_vram_write_scheduler;
    localparam int AW = 12;
    localparam int DEPTH = 16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    int strobes = 0;
    int s0;
    logic [AW+7:0] exp_q[$];
    vram_write_scheduler_if #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) bus ();
    vram_write_scheduler #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk_12_5875(clk),
        .rst_n(rst_n),
        .bus(bus)
    );
    always #5 clk = ~clk;
    // Expected writes are queued by the stimulus; every strobe pops one and compares.
    always @(negedge clk) begin
        if (rst_n && bus.vram_write_enable === 1'b1) begin
            strobes++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_strobe: got %h/%h, none expected", bus.vram_address, bus.vram_data);
            end else begin
                logic [AW+7:0] e;
                e = exp_q.pop_front();
                if ({bus.vram_address, bus.vram_data} !== e) begin
                    failures++;
                    $display("FAIL vram_write: got %h/%h expected %h/%h",
                             bus.vram_address, bus.vram_data, e[AW+7:8], e[7:0]);
                end
            end
        end
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic push(input logic [AW-1:0] a, input logic [7:0] d, input bit q);
        bus.cpu_address = a;
        bus.cpu_data = d;
        bus.cpu_write_enable = 1'b1;
        cyc();
        bus.cpu_write_enable = 1'b0;
        if (q) exp_q.push_back({a, d});
    endtask
    task automatic zero_inputs();
        bus.cpu_address = '0;
        bus.cpu_data = '0;
        bus.cpu_write_enable = 1'b0;
        bus.fill_address = '0;
        bus.fill_data = '0;
        bus.fill_write_enable = 1'b0;
        bus.fill_in_progress = 1'b0;
        bus.in_vblank = 1'b0;
        bus.clr_overflow = 1'b0;
    endtask
    initial begin
        zero_inputs();
        repeat (2) cyc();
        rst_n = 1'b1;
        // make outputs non-zero, then reset asynchronously mid-cycle
        bus.fill_in_progress = 1'b1;
        bus.fill_write_enable = 1'b1;
        bus.fill_address = 12'h123;
        bus.fill_data = 8'h5A;
        exp_q.push_back({12'h123, 8'h5A});
        cyc();
        zero_inputs();
        chk("fill_mode", 32'(bus.mode), 1);
        push(12'h7F0, 8'h11, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        bus.cpu_address = AW'($urandom);
        bus.cpu_data = 8'($urandom);
        bus.cpu_write_enable = 1'b1;
        bus.fill_address = AW'($urandom);
        bus.fill_data = 8'($urandom);
        bus.fill_write_enable = 1'b1;
        bus.fill_in_progress = 1'($urandom);
        bus.in_vblank = 1'b1;
        #2;
        chk("rst_addr", 32'(bus.vram_address), 0);
        chk("rst_data", 32'(bus.vram_data), 0);
        chk("rst_we", 32'(bus.vram_write_enable), 0);
        chk("rst_mode", 32'(bus.mode), 0);
        chk("rst_pending", 32'(bus.pending), 0);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_overflow", 32'(bus.overflow), 0);
        cyc();
        chk("rst_hold_we", 32'(bus.vram_write_enable), 0);
        zero_inputs();
        rst_n = 1'b1;
        // queue then drain
        s0 = strobes;
        push(12'h800, 8'h0F, 1'b1);
        push(12'h801, 8'h0F, 1'b1);
        push(12'h803, 8'h07, 1'b1);
        chk("q_pending", 32'(bus.pending), 3);
        chk("q_no_strobe", 32'(strobes - s0), 0);
        bus.in_vblank = 1'b1;
        cyc();
        chk("drain_first_we", 32'(bus.vram_write_enable), 1);
        chk("drain_mode", 32'(bus.mode), 2);
        cyc();
        cyc();
        chk("drain_pending", 32'(bus.pending), 0);
        cyc();
        chk("drain_idle_mode", 32'(bus.mode), 0);
        chk("drain_idle_we", 32'(bus.vram_write_enable), 0);
        chk("drain_count", 32'(strobes - s0), 3);
        bus.in_vblank = 1'b0;
        // overflow and pointer wrap, twice
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i <= DEPTH; i++)
                push(AW'(12'h100 + r * 32 + i), 8'(r * 16 + i), i < DEPTH);
            chk("ovf_full", 32'(bus.full), 1);
            chk("ovf_flag", 32'(bus.overflow), 1);
            chk("ovf_pending", 32'(bus.pending), DEPTH);
            s0 = strobes;
            bus.in_vblank = 1'b1;
            repeat (DEPTH + 1) cyc();
            bus.in_vblank = 1'b0;
            chk("wrap_pending", 32'(bus.pending), 0);
            chk("wrap_full", 32'(bus.full), 0);
            chk("wrap_count", 32'(strobes - s0), DEPTH);
        end
        chk("ovf_sticky", 32'(bus.overflow), 1);
        bus.clr_overflow = 1'b1;
        cyc();
        bus.clr_overflow = 1'b0;
        chk("ovf_clear", 32'(bus.overflow), 0);
        // fill priority with two CPU entries queued
        push(12'h200, 8'hA1, 1'b0);
        push(12'h201, 8'hA2, 1'b0);
        bus.fill_in_progress = 1'b1;
        bus.in_vblank = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.fill_address = AW'(i);
            bus.fill_data = 8'h0F;
            bus.fill_write_enable = 1'b1;
            exp_q.push_back({AW'(i), 8'h0F});
            cyc();
            if (i == 0) chk("fill_mode2", 32'(bus.mode), 1);
        end
        chk("fill_pending", 32'(bus.pending), 2);
        bus.fill_in_progress = 1'b0;
        bus.fill_write_enable = 1'b0;
        exp_q.push_back({12'h200, 8'hA1});
        exp_q.push_back({12'h201, 8'hA2});
        repeat (3) cyc();
        chk("fill_after_pending", 32'(bus.pending), 0);
        bus.in_vblank = 1'b0;
        // vblank cut after two cycles
        for (int i = 0; i < 5; i++) push(AW'(12'h300 + i), 8'(8'h30 + i), 1'b1);
        s0 = strobes;
        bus.in_vblank = 1'b1;
        cyc();
        cyc();
        bus.in_vblank = 1'b0;
        cyc();
        chk("cut_pending", 32'(bus.pending), 3);
        chk("cut_count", 32'(strobes - s0), 2);
        bus.in_vblank = 1'b1;
        push(12'h3AA, 8'h55, 1'b1);
        chk("pushpop_pending", 32'(bus.pending), 3);
        repeat (4) cyc();
        chk("cut_drain_pending", 32'(bus.pending), 0);
        bus.in_vblank = 1'b0;
        // overflow set beats clear in the same cycle
        for (int i = 0; i < DEPTH; i++) push(AW'(12'h400 + i), 8'(8'hC0 + i), 1'b1);
        chk("col_full", 32'(bus.full), 1);
        chk("col_ovf_pre", 32'(bus.overflow), 0);
        bus.clr_overflow = 1'b1;
        push(12'h4FF, 8'hEE, 1'b0);
        chk("col_ovf_set_wins", 32'(bus.overflow), 1);
        cyc();
        bus.clr_overflow = 1'b0;
        chk("col_ovf_cleared", 32'(bus.overflow), 0);
        bus.in_vblank = 1'b1;
        repeat (DEPTH + 1) cyc();
        bus.in_vblank = 1'b0;
        chk("col_drain_pending", 32'(bus.pending), 0);
        repeat (3) cyc();
        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
